// File: rtl/toi2s_pkg.sv
// Shared constants and register-bank types for the toi2s top level.
// Holds the PWM defaults, mode/direction encodings and the sys_cfg PWM fields.
package toi2s_pkg;

    localparam int PWM_N_CH  = 4;
    localparam int PWM_W     = 8;
    localparam int PWM_PRE_W = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam logic PWM_DIR_UP   = 1'b0;
    localparam logic PWM_DIR_DOWN = 1'b1;

    typedef struct packed {
        logic [PWM_N_CH-1:0][PWM_W-1:0] pwm_duty;
        logic [PWM_W-1:0]               pwm_period;
        logic                           pwm_center;
        logic [PWM_PRE_W-1:0]           pwm_prescale;
        logic [PWM_N_CH-1:0]            pwm_ch_en;
        logic [PWM_N_CH-1:0]            pwm_invert;
    } rb_sys_cfg_wire_t;

    // Flattens the struct's duty array into the channel-major bus the PWM block takes.
    function automatic logic [PWM_N_CH*PWM_W-1:0] pwm_flat_duty(input rb_sys_cfg_wire_t cfg);
        logic [PWM_N_CH*PWM_W-1:0] flat;
        flat = '0;
        for (int i = 0; i < PWM_N_CH; i++) begin
            flat[i*PWM_W +: PWM_W] = cfg.pwm_duty[i];
        end
        return flat;
    endfunction

endpackage

// File: rtl/pwm_multi_ch_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, period boundary detection
// and the shadow-load strobe that moves period/mode (and duties) into use.
module pwm_timebase
    import toi2s_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] cfg_period_i,
    input  logic             cfg_center_i,
    input  logic [PRE_W-1:0] cfg_prescale_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             shadow_load_o,
    output logic             period_first_o
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    pwm_mode_e        mode_sh_q, mode_sh_d;
    logic             dir_q, dir_d;
    logic             first_q, first_d;
    logic             tick;
    logic             period_end;
    logic             shadow_load;

    // A lowered prescale value wraps at once instead of running past it.
    assign tick = ena_i && (pre_cnt_q >= cfg_prescale_i);

    always_comb begin
        period_end = 1'b0;
        if (mode_sh_q == PWM_CENTER) begin
            period_end = (dir_q == PWM_DIR_DOWN) && (cnt_q == '0);
        end else begin
            period_end = (cnt_q == period_sh_q);
        end
    end

    assign shadow_load = !ena_i || (tick && period_end);

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        first_d     = first_q;
        period_sh_d = period_sh_q;
        mode_sh_d   = mode_sh_q;

        if (!ena_i) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            dir_d     = PWM_DIR_UP;
            first_d   = 1'b1;
        end else begin
            first_d   = 1'b0;
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            if (tick) begin
                if (period_end) begin
                    cnt_d   = '0;
                    dir_d   = PWM_DIR_UP;
                    first_d = 1'b1;
                end else if (mode_sh_q == PWM_EDGE) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (dir_q == PWM_DIR_UP) begin
                    // Turning around at the top keeps cnt, so T is held for two ticks.
                    if (cnt_q == period_sh_q) begin
                        dir_d = PWM_DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        if (shadow_load) begin
            period_sh_d = cfg_period_i;
            mode_sh_d   = pwm_mode_e'(cfg_center_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            pre_cnt_q   <= '0;
            cnt_q       <= '0;
            dir_q       <= PWM_DIR_UP;
            first_q     <= 1'b1;
            period_sh_q <= '0;
            mode_sh_q   <= PWM_EDGE;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            first_q     <= first_d;
            period_sh_q <= period_sh_d;
            mode_sh_q   <= mode_sh_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign shadow_load_o  = shadow_load;
    assign period_first_o = first_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator on one shared timebase, with double-buffered
// duty and per-channel live enable/inversion on registered outputs.
module pwm_multi_ch
    import toi2s_pkg::*;
#(
    parameter int N_CH  = PWM_N_CH,
    parameter int WIDTH = PWM_W,
    parameter int PRE_W = PWM_PRE_W
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  ena,
    input  logic [N_CH*WIDTH-1:0] cfg_duty,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic                  cfg_center,
    input  logic [PRE_W-1:0]      cfg_prescale,
    input  logic [N_CH-1:0]       cfg_ch_en,
    input  logic [N_CH-1:0]       cfg_invert,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  period_start
);

    logic [WIDTH-1:0] cnt;
    logic             shadow_load;
    logic             period_first;
    logic             period_start_q, period_start_d;

    pwm_timebase #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk            (clk),
        .resetb         (resetb),
        .ena_i          (ena),
        .cfg_period_i   (cfg_period),
        .cfg_center_i   (cfg_center),
        .cfg_prescale_i (cfg_prescale),
        .cnt_o          (cnt),
        .shadow_load_o  (shadow_load),
        .period_first_o (period_first)
    );

    // Registered alongside pwm_out so the pulse lines up with the count-0 output.
    assign period_start_d = ena & period_first;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
            logic             out_q, out_d;
            logic             raw;

            assign duty_sh_d = shadow_load ? cfg_duty[gi*WIDTH +: WIDTH] : duty_sh_q;
            // cnt never exceeds T, so D >= T+1 saturates high without extra logic.
            assign raw   = (cnt < duty_sh_q);
            assign out_d = (ena & cfg_ch_en[gi] & raw) ^ cfg_invert[gi];

            always_ff @(posedge clk) begin
                if (!resetb) begin
                    duty_sh_q <= '0;
                    out_q     <= 1'b0;
                end else begin
                    duty_sh_q <= duty_sh_d;
                    out_q     <= out_d;
                end
            end

            assign pwm_out[gi] = out_q;
        end
    endgenerate

endmodule
